// File: rtl/unsigned8b_err_metric_accum_if.sv
// Sample stream, campaign control and result bus of the approximate-multiplier error-metric accumulator.
// The master feeds samples and starts campaigns; the slave is the accumulator.
interface unsigned8b_err_metric_accum_if #(
    parameter int W     = 8,
    parameter int CNT_W = 2*W+1,
    parameter int SAE_W = 2*W+CNT_W,
    parameter int SSE_W = 4*W+CNT_W
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic [2*W-1:0]   in_z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [2*W-1:0]   max_abs_err;
    logic [SAE_W-1:0] sum_abs_err;
    logic [SSE_W-1:0] sum_sq_err;

    modport master (
        output start, num_samples, in_valid, in_x, in_y, in_z,
        input  in_ready, busy, done, sample_cnt, err_cnt, max_abs_err, sum_abs_err, sum_sq_err
    );

    modport slave (
        input  start, num_samples, in_valid, in_x, in_y, in_z,
        output in_ready, busy, done, sample_cnt, err_cnt, max_abs_err, sum_abs_err, sum_sq_err
    );
endinterface

// File: rtl/unsigned8b_err_metric_accum.sv
// Scores an approximate WxW multiplier: recomputes x*y for each streamed sample and accumulates
// sum |e|, sum e^2, max |e|, nonzero-error count and sample count over one campaign per start.
module unsigned8b_err_metric_accum #(
    parameter int W     = 8,
    parameter int CNT_W = 2*W+1,
    parameter int SAE_W = 2*W+CNT_W,
    parameter int SSE_W = 4*W+CNT_W
) (
    input logic clk,
    input logic rst_n,
    unsigned8b_err_metric_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int SAE_X = ((SAE_W > 2*W) ? SAE_W : 2*W) + 1;
    localparam int SSE_X = ((SSE_W > 4*W) ? SSE_W : 4*W) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] numLat_q, numLat_d;
    logic [CNT_W-1:0] acceptCnt_q, acceptCnt_d;
    logic             inReady, accept, clearRes;

    logic             inV_q;
    logic [W-1:0]     inX_q, inY_q;
    logic [2*W-1:0]   inZ_q;
    logic             s1V_q;
    logic [2*W:0]     s1Err_q;
    logic [2*W-1:0]   s1Abs_q;

    logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;
    logic [2*W-1:0]   maxAbs_q, maxAbs_d;
    logic [SAE_W-1:0] sumAbs_q, sumAbs_d;
    logic [SSE_W-1:0] sumSq_q, sumSq_d;

    logic [2*W-1:0]   exactC;
    logic [2*W:0]     errC, negErrC;
    logic [2*W-1:0]   absC;
    logic [4*W-1:0]   sq;
    logic [CNT_W:0]   sampleSum, errSum;
    logic [SAE_X-1:0] saeSum;
    logic [SSE_X-1:0] sseSum;

    assign inReady = (state_q == RUN) && (acceptCnt_q < numLat_q);
    assign accept  = inReady && bus.in_valid;

    always_comb begin
        state_d     = state_q;
        numLat_d    = numLat_q;
        acceptCnt_d = acceptCnt_q;
        clearRes    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    clearRes    = 1'b1;
                    acceptCnt_d = '0;
                    numLat_d    = bus.num_samples;
                    state_d     = (bus.num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acceptCnt_d = acceptCnt_q + CNT_W'(1);
                    if (acceptCnt_d == numLat_q) state_d = DRAIN;
                end
            end
            // Leaving when only S1 is occupied lets DONE rise on the same edge as the final update.
            DRAIN: begin
                if (!inV_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            numLat_q    <= '0;
            acceptCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            numLat_q    <= numLat_d;
            acceptCnt_q <= acceptCnt_d;
        end
    end

    assign exactC  = {{W{1'b0}}, inX_q} * {{W{1'b0}}, inY_q};
    assign errC    = {1'b0, inZ_q} - {1'b0, exactC};
    assign negErrC = -errC;
    assign absC    = errC[2*W] ? negErrC[2*W-1:0] : errC[2*W-1:0];

    // Accepted samples are captured first, then S1 holds e and |e| for the accumulate stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inV_q   <= 1'b0;
            inX_q   <= '0;
            inY_q   <= '0;
            inZ_q   <= '0;
            s1V_q   <= 1'b0;
            s1Err_q <= '0;
            s1Abs_q <= '0;
        end else begin
            inV_q <= accept;
            if (accept) begin
                inX_q <= bus.in_x;
                inY_q <= bus.in_y;
                inZ_q <= bus.in_z;
            end
            s1V_q <= inV_q;
            if (inV_q) begin
                s1Err_q <= errC;
                s1Abs_q <= absC;
            end
        end
    end

    assign sq        = {{2*W{1'b0}}, s1Abs_q} * {{2*W{1'b0}}, s1Abs_q};
    assign sampleSum = {1'b0, sampleCnt_q} + (CNT_W+1)'(1);
    assign errSum    = {1'b0, errCnt_q} + (CNT_W+1)'(s1Err_q != '0);
    assign saeSum    = SAE_X'(sumAbs_q) + SAE_X'(s1Abs_q);
    assign sseSum    = SSE_X'(sumSq_q) + SSE_X'(sq);

    // Every accumulator sticks at all-ones instead of wrapping when the widths are narrowed.
    always_comb begin
        sampleCnt_d = sampleSum[CNT_W] ? '1 : sampleSum[CNT_W-1:0];
        errCnt_d    = errSum[CNT_W] ? '1 : errSum[CNT_W-1:0];
        maxAbs_d    = (s1Abs_q > maxAbs_q) ? s1Abs_q : maxAbs_q;
        sumAbs_d    = (saeSum > SAE_X'({SAE_W{1'b1}})) ? '1 : saeSum[SAE_W-1:0];
        sumSq_d     = (sseSum > SSE_X'({SSE_W{1'b1}})) ? '1 : sseSum[SSE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampleCnt_q <= '0;
            errCnt_q    <= '0;
            maxAbs_q    <= '0;
            sumAbs_q    <= '0;
            sumSq_q     <= '0;
        end else if (clearRes) begin
            sampleCnt_q <= '0;
            errCnt_q    <= '0;
            maxAbs_q    <= '0;
            sumAbs_q    <= '0;
            sumSq_q     <= '0;
        end else if (s1V_q) begin
            sampleCnt_q <= sampleCnt_d;
            errCnt_q    <= errCnt_d;
            maxAbs_q    <= maxAbs_d;
            sumAbs_q    <= sumAbs_d;
            sumSq_q     <= sumSq_d;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
    assign bus.sample_cnt  = sampleCnt_q;
    assign bus.err_cnt     = errCnt_q;
    assign bus.max_abs_err = maxAbs_q;
    assign bus.sum_abs_err = sumAbs_q;
    assign bus.sum_sq_err  = sumSq_q;
endmodule

// File: tb/tb_unsigned8b_err_metric_accum.sv
// Bench for the error-metric accumulator: directed and random campaigns scored against
// metrics computed directly from the list of accepted samples.
module tb_unsigned8b_err_metric_accum;
    localparam int W     = 8;
    localparam int CNT_W = 2*W+1;
    localparam int SAE_W = 2*W+CNT_W;
    localparam int SSE_W = 4*W+CNT_W;

    typedef struct {
        int x;
        int y;
        int z;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    sample_t stimQ[$];
    sample_t accQ[$];

    always #5 clk = ~clk;

    unsigned8b_err_metric_accum_if #(.W(W), .CNT_W(CNT_W), .SAE_W(SAE_W), .SSE_W(SSE_W)) bus ();

    unsigned8b_err_metric_accum #(.W(W), .CNT_W(CNT_W), .SAE_W(SAE_W), .SSE_W(SSE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Every comparison goes through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int n);
        bus.start       = 1'b1;
        bus.num_samples = n[CNT_W-1:0];
        tick();
        bus.start = 1'b0;
    endtask

    task automatic driveSample(input sample_t s);
        bus.in_x = s.x[W-1:0];
        bus.in_y = s.y[W-1:0];
        bus.in_z = s.z[2*W-1:0];
    endtask

    // Starts a campaign of n samples from stimQ; returns just after the edge of the last accept.
    task automatic applyStimulus(input int n, input bit gaps, input int budget, input string tag);
        int idx = 0;
        int c = 0;
        bit acc;
        accQ.delete();
        pulseStart(n);
        while (idx < n && c < budget) begin
            bus.in_valid = (gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            driveSample(stimQ[idx]);
            acc = bus.in_valid && bus.in_ready;
            tick();
            c++;
            if (acc) begin
                accQ.push_back(stimQ[idx]);
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, "_accepted"}, 64'(idx), 64'(n));
    endtask

    task automatic feedOne(input sample_t s, input int budget);
        int c = 0;
        bus.in_valid = 1'b1;
        driveSample(s);
        while (bus.in_ready !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        tick();
        accQ.push_back(s);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int c = 0;
        while (bus.done !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd1);
    endtask

    // Reference metrics straight from the accepted sample list, using plain integer arithmetic.
    task automatic checkModel(input string tag);
        longint cnt = 0, errs = 0, mx = 0, sa = 0, ss = 0, e, a;
        foreach (accQ[i]) begin
            e = longint'(accQ[i].z) - longint'(accQ[i].x) * longint'(accQ[i].y);
            a = (e < 0) ? -e : e;
            cnt++;
            if (a != 0) errs++;
            if (a > mx) mx = a;
            sa += a;
            ss += a * a;
        end
        checkOutput({tag, "_busy"},    64'(bus.busy), 64'd0);
        checkOutput({tag, "_samples"}, 64'(bus.sample_cnt), 64'(cnt));
        checkOutput({tag, "_errcnt"},  64'(bus.err_cnt), 64'(errs));
        checkOutput({tag, "_max"},     64'(bus.max_abs_err), 64'(mx));
        checkOutput({tag, "_sumabs"},  64'(bus.sum_abs_err), 64'(sa));
        checkOutput({tag, "_sumsq"},   64'(bus.sum_sq_err), 64'(ss));
    endtask

    task automatic pushSample(input int x, input int y, input int z);
        sample_t s;
        s.x = x;
        s.y = y;
        s.z = z;
        stimQ.push_back(s);
    endtask

    initial begin
        int x, y, p, mode;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.in_valid    = 1'b0;
        bus.in_x        = '0;
        bus.in_y        = '0;
        bus.in_z        = '0;

        tick();
        tick();
        checkOutput("rst_done",    64'(bus.done), 64'd0);
        checkOutput("rst_busy",    64'(bus.busy), 64'd0);
        checkOutput("rst_ready",   64'(bus.in_ready), 64'd0);
        checkOutput("rst_samples", 64'(bus.sample_cnt), 64'd0);
        checkOutput("rst_sumsq",   64'(bus.sum_sq_err), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] exact 16x16 sweep");
        stimQ.delete();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) pushSample(i, j, i * j);
        applyStimulus(256, 1'b0, 400, "exact");
        waitDone(10, "exact");
        checkModel("exact");
        checkOutput("exact_cnt_const", 64'(bus.sample_cnt), 64'd256);

        $display("[TB] single error and pipeline latency");
        stimQ.delete();
        pushSample(3, 255, 640);
        applyStimulus(1, 1'b0, 20, "single");
        checkOutput("single_t0_sumabs", 64'(bus.sum_abs_err), 64'd0);
        tick();
        checkOutput("single_t1_sumabs", 64'(bus.sum_abs_err), 64'd0);
        checkOutput("single_t1_done",   64'(bus.done), 64'd0);
        tick();
        checkOutput("single_t2_sumabs", 64'(bus.sum_abs_err), 64'd125);
        checkOutput("single_t2_done",   64'(bus.done), 64'd1);
        checkModel("single");
        checkOutput("single_sumsq_const", 64'(bus.sum_sq_err), 64'd15625);

        $display("[TB] worst case");
        stimQ.delete();
        pushSample(255, 255, 0);
        pushSample(1, 1, 3);
        applyStimulus(2, 1'b0, 20, "worst");
        waitDone(10, "worst");
        checkModel("worst");
        checkOutput("worst_sumsq_const", 64'(bus.sum_sq_err), 64'd4228250629);

        $display("[TB] backpressure");
        stimQ.delete();
        for (int i = 0; i < 8; i++) pushSample(i + 1, 7, (i + 1) * 7 + i);
        applyStimulus(4, 1'b0, 40, "bp");
        bus.in_valid = 1'b1;
        driveSample(stimQ[4]);
        checkOutput("bp_ready_dropped", 64'(bus.in_ready), 64'd0);
        waitDone(10, "bp");
        tick();
        tick();
        checkOutput("bp_ready_done", 64'(bus.in_ready), 64'd0);
        checkModel("bp");
        bus.in_valid = 1'b0;

        $display("[TB] random campaign with idle gaps");
        stimQ.delete();
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            p = x * y;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: pushSample(x, y, p);
                1: pushSample(x, y, int'($urandom_range(0, 65535)));
                2: pushSample(x, y, (p + int'($urandom_range(1, 300))) & 16'hFFFF);
                default: pushSample(x, y, (p - int'($urandom_range(1, 300))) & 16'hFFFF);
            endcase
        end
        applyStimulus(40, 1'b1, 400, "rand");
        waitDone(10, "rand");
        checkModel("rand");

        $display("[TB] zero-length campaign");
        pulseStart(0);
        accQ.delete();
        checkOutput("zero_done", 64'(bus.done), 64'd1);
        checkModel("zero");

        $display("[TB] start ignored while running");
        stimQ.delete();
        pushSample(10, 20, 201);
        pushSample(30, 40, 1200);
        pushSample(50, 60, 2990);
        accQ.delete();
        pulseStart(3);
        feedOne(stimQ[0], 10);
        bus.start       = 1'b1;
        bus.num_samples = CNT_W'(1);
        tick();
        bus.start = 1'b0;
        checkOutput("restart_busy",  64'(bus.busy), 64'd1);
        checkOutput("restart_ready", 64'(bus.in_ready), 64'd1);
        feedOne(stimQ[1], 10);
        feedOne(stimQ[2], 10);
        waitDone(10, "restart");
        checkModel("restart");

        $display("[TB] asynchronous reset mid-run");
        accQ.delete();
        pulseStart(5);
        feedOne('{x: 3, y: 255, z: 640}, 10);
        feedOne('{x: 255, y: 255, z: 0}, 10);
        tick();
        tick();
        checkOutput("abort_pre_samples", 64'(bus.sample_cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy",    64'(bus.busy), 64'd0);
        checkOutput("abort_ready",   64'(bus.in_ready), 64'd0);
        checkOutput("abort_samples", 64'(bus.sample_cnt), 64'd0);
        checkOutput("abort_max",     64'(bus.max_abs_err), 64'd0);
        checkOutput("abort_sumabs",  64'(bus.sum_abs_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_idle_done", 64'(bus.done), 64'd0);

        $display("[TB] exhaustive off-by-one sweep");
        stimQ.delete();
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 256; j++) pushSample(i, j, i * j + 1);
        applyStimulus(65536, 1'b0, 70000, "exh");
        waitDone(10, "exh");
        checkModel("exh");
        checkOutput("exh_max_const",   64'(bus.max_abs_err), 64'd1);
        checkOutput("exh_sumsq_const", 64'(bus.sum_sq_err), 64'd65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
